multicycle_control_fsm: RTL and testbench

- Sequencing controller for the multi-cycle RV32I datapath: FETCH, DECODE, EXECUTE, MEM, WB.
- Decodes the same four opcode classes as the single-cycle control unit:
  - R-type 0110011
  - Load 0000011
  - Store 0100011
  - Branch 1100011
- Spreads the resulting strobes over cycles.
- Handshakes with a variable-latency memory and counts retired instructions.

---
 rtl/multicycle_control_fsm.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle RV32I datapath (FETCH/DECODE/EXECUTE/MEM/WB).
// Optional ILLEGAL_TRAP_EN: unknown opcodes trap until reset instead of retiring as NOPs.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             branch_taken,
  output logic             instr_done,
  output logic             mem_error,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R   = 3'd0,
    C_LD  = 3'd1,
    C_ST  = 3'd2,
    C_BR  = 3'd3,
    C_BAD = 3'd4
  } cls_t;

  state_t     st, nxt;
  cls_t       cls_q, cls_d;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       timeout;

  always_comb begin
    cls_d = C_BAD;
    case (opcode)
      7'b0110011: cls_d = C_R;
      7'b0000011: cls_d = C_LD;
      7'b0100011: cls_d = C_ST;
      7'b1100011: cls_d = C_BR;
      default:    cls_d = C_BAD;
    endcase
  end

  // Fires on the MEM_TIMEOUT-th consecutive not-ready cycle; a ready in that cycle wins.
  assign waiting = (st == FETCH) || (st == MEM);
  assign timeout = waiting && !mem_ready && (wait_cnt == 8'(MEM_TIMEOUT - 1));

  always_comb begin
    nxt           = st;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src       = 1'b0;
    alu_op        = 2'b00;
    branch_taken  = 1'b0;
    instr_done    = 1'b0;
    mem_error     = 1'b0;
    illegal_instr = 1'b0;
    case (st)
      FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = DECODE;
        end else if (timeout) begin
          mem_error = 1'b1;
        end
      end
      DECODE: begin
        if (cls_d == C_BAD) begin
`ifdef ILLEGAL_TRAP_EN
          nxt = TRAP;
`else
          instr_done = 1'b1;
          nxt        = FETCH;
`endif
        end else begin
          nxt = EXECUTE;
        end
      end
      EXECUTE: begin
        case (cls_q)
          C_R: begin
            alu_op = 2'b10;
            nxt    = WB;
          end
          C_LD, C_ST: begin
            alu_src = 1'b1;
            nxt     = MEM;
          end
          C_BR: begin
            alu_op       = 2'b01;
            branch_taken = zero;
            pc_write     = zero;
            instr_done   = 1'b1;
            nxt          = FETCH;
          end
          default: nxt = FETCH;
        endcase
      end
      MEM: begin
        mem_read  = (cls_q == C_LD);
        mem_write = (cls_q == C_ST);
        if (mem_ready) begin
          if (cls_q == C_LD) begin
            nxt = WB;
          end else begin
            instr_done = 1'b1;
            nxt        = FETCH;
          end
        end else if (timeout) begin
          mem_error = 1'b1;
          nxt       = FETCH;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LD);
        alu_op     = (cls_q == C_R) ? 2'b10 : 2'b00;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        illegal_instr = 1'b1;
        nxt           = TRAP;
`else
        nxt = FETCH;
`endif
      end
      default: nxt = FETCH;
    endcase
    // Reset drops the in-flight instruction silently, whatever state it was in.
    if (reset) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src       = 1'b0;
      alu_op        = 2'b00;
      branch_taken  = 1'b0;
      instr_done    = 1'b0;
      mem_error     = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= FETCH;
      cls_q       <= C_R;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      st <= nxt;
      if (st == DECODE) cls_q <= cls_d;
      if ((nxt != st) || mem_ready || timeout) begin
        wait_cnt <= '0;
      end else if (waiting) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (instr_done) instr_count <= instr_count + CNT_W'(1);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm; expectations are hand-derived cycle by cycle.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  state;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg, alu_src;
  logic [1:0]  alu_op;
  logic        branch_taken, instr_done, mem_error, illegal_instr;
  logic [31:0] instr_count;
  logic [12:0] strobes;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(state), .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_op(alu_op), .branch_taken(branch_taken),
    .instr_done(instr_done), .mem_error(mem_error), .illegal_instr(illegal_instr),
    .instr_count(instr_count)
  );

  assign strobes = {pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg,
                    alu_src, alu_op, branch_taken, instr_done, mem_error, illegal_instr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven and outputs sampled mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    next_cycle(); next_cycle();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'(strobes), 32'd0);
    chk("rst_count", instr_count, 32'd0);
    reset = 1'b0; #1;
    chk("fetch_mem_read", 32'(mem_read), 32'd1);

    // R-type, memory always ready: F D E WB
    opcode = OP_R; mem_ready = 1'b1; #1;
    chk("r_f_state", 32'(state), 32'd0);
    chk("r_f_irpc", 32'({ir_write, pc_write}), 32'b11);
    next_cycle();
    chk("r_d_state", 32'(state), 32'd1);
    next_cycle();
    chk("r_e_state", 32'(state), 32'd2);
    chk("r_e_aluop", 32'({alu_src, alu_op}), 32'b010);
    next_cycle();
    chk("r_wb_state", 32'(state), 32'd4);
    chk("r_wb_strobes", 32'({reg_write, mem_to_reg, alu_op, instr_done}), 32'b10101);
    next_cycle();
    chk("r_count", instr_count, 32'd1);
    chk("r_back_fetch", 32'(state), 32'd0);

    // Load with three not-ready MEM cycles: F D E M M M M WB
    opcode = OP_LD; #1;
    next_cycle(); next_cycle();
    chk("ld_e_alusrc", 32'({alu_src, alu_op}), 32'b100);
    mem_ready = 1'b0;
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ld_mem_wait", 32'({state, mem_read, mem_write, instr_done}), {29'd0, 3'd3} << 3 | 32'b100);
      next_cycle();
    end
    mem_ready = 1'b1; #1;
    chk("ld_mem_ready", 32'({state, mem_read}), 32'b0111);
    next_cycle();
    chk("ld_wb", 32'({state, reg_write, mem_to_reg, instr_done}), 32'b100111);
    next_cycle();
    chk("ld_count", instr_count, 32'd2);

    // Taken branch, then not-taken with opcode changed after DECODE
    opcode = OP_BR; zero = 1'b1;
    next_cycle(); next_cycle();
    chk("br1_e", 32'({state, alu_op, pc_write, branch_taken, instr_done}), 32'b01001111);
    next_cycle();
    chk("br1_back", 32'(state), 32'd0);
    chk("br1_count", instr_count, 32'd3);
    zero = 1'b0;
    next_cycle(); next_cycle();
    opcode = OP_R; #1;
    chk("br0_e", 32'({state, alu_op, pc_write, branch_taken, instr_done}), 32'b01001001);
    next_cycle();
    chk("br0_count", instr_count, 32'd4);

    // Store that never sees ready: error on the 15th MEM wait cycle
    opcode = OP_ST;
    next_cycle(); next_cycle();
    mem_ready = 1'b0;
    next_cycle();
    for (int i = 1; i <= 15; i++) begin
      #1;
      chk("st_to_write", 32'({state, mem_write}), 32'b0111);
      chk("st_to_err", 32'({mem_error, instr_done, pc_write}), (i == 15) ? 32'b100 : 32'b000);
      next_cycle();
    end
    chk("st_to_back", 32'(state), 32'd0);
    chk("st_to_count", instr_count, 32'd4);

    // Store with ready on the 15th wait cycle: no error, retires
    mem_ready = 1'b1;
    next_cycle(); next_cycle();
    mem_ready = 1'b0;
    next_cycle();
    for (int i = 1; i < 15; i++) next_cycle();
    mem_ready = 1'b1; #1;
    chk("st_rdy15", 32'({state, mem_write, mem_error, instr_done}), 32'b011101);
    next_cycle();
    chk("st_rdy15_count", instr_count, 32'd5);

    // Reset for two cycles in the middle of a store's MEM wait
    next_cycle(); next_cycle();
    mem_ready = 1'b0;
    next_cycle(); next_cycle();
    chk("mid_mem_state", 32'(state), 32'd3);
    reset = 1'b1; #1;
    chk("mid_rst_strobes", 32'(strobes), 32'd0);
    next_cycle();
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_strobes2", 32'(strobes), 32'd0);
    next_cycle();
    chk("mid_rst_count", instr_count, 32'd0);
    reset = 1'b0; mem_ready = 1'b1; opcode = OP_BAD; #1;
    chk("post_rst_fetch", 32'({state, mem_read, ir_write}), 32'b00011);
    next_cycle();
    chk("bad_d_state", 32'(state), 32'd1);
`ifdef ILLEGAL_TRAP_EN
    chk("bad_d_done", 32'(instr_done), 32'd0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      chk("trap_state", 32'(state), 32'd5);
      chk("trap_strobes", 32'(strobes), 32'd1);
      next_cycle();
    end
    chk("trap_count", instr_count, 32'd0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; #1;
    chk("trap_exit", 32'({state, illegal_instr}), 32'd0);
`else
    chk("nop_d_done", 32'({instr_done, illegal_instr}), 32'b10);
    next_cycle();
    chk("nop_back", 32'(state), 32'd0);
    chk("nop_count", instr_count, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
